// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited word requests to imem and
// buffers in-order responses for decode. Optional misaligned-redirect fault: FETCH_MISALIGN_CHECK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic [31:0] pc_next_o,
    input  logic        instr_ready_i,
    output logic        fetch_fault_o
);
    localparam int          PW     = (DEPTH > 2) ? 2 : 1;
    localparam logic [2:0]  DEPTH3 = 3'(DEPTH);

    logic [31:0] r_fetch_pc;
    logic [2:0]  r_inflight;
    logic [2:0]  r_discard;
    logic [2:0]  r_count;
    logic [PW-1:0] r_wr_ptr, r_rd_ptr;
    logic [PW-1:0] r_pq_wr, r_pq_rd;
    logic [31:0] r_fifo_pc    [DEPTH];
    logic [31:0] r_fifo_instr [DEPTH];
    logic [31:0] r_pq         [DEPTH];

    logic [31:0] w_redir_pc;
    logic        w_fault;
    logic [2:0]  w_credit_sum;
    logic        w_grant;
    logic        w_drop;
    logic        w_accept;
    logic        w_push;
    logic        w_pop;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic r_fault;

    assign w_redir_pc = redirect_pc_i;

    // A misaligned redirect parks the stage until an aligned redirect arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_fault <= 1'b0;
        end else if (redirect_i) begin
            r_fault <= |redirect_pc_i[1:0];
        end
    end

    assign w_fault       = r_fault;
    assign fetch_fault_o = r_fault;
`else
    assign w_redir_pc    = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_fault       = 1'b0;
    assign fetch_fault_o = 1'b0;
`endif

    // Every slot is either in flight, being discarded, or buffered; never exceed DEPTH.
    assign w_credit_sum = r_inflight + r_discard + r_count;
    assign imem_req_o   = rst_i & ~redirect_i & (w_credit_sum < DEPTH3) & ~w_fault;
    assign imem_addr_o  = r_fetch_pc;

    assign w_grant  = imem_req_o & imem_gnt_i;
    assign w_drop   = imem_rvalid_i & (r_discard != 3'd0);
    assign w_accept = imem_rvalid_i & (r_discard == 3'd0);
    assign w_push   = w_accept & ~redirect_i;
    assign w_pop    = instr_valid_o & instr_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_inflight <= 3'd0;
            r_discard  <= 3'd0;
            r_count    <= 3'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pq_wr    <= '0;
            r_pq_rd    <= '0;
        end else if (redirect_i) begin
            // Everything still outstanding becomes stale; one may be retiring right now.
            r_fetch_pc <= w_redir_pc;
            r_inflight <= 3'd0;
            r_discard  <= r_discard + r_inflight - {2'b00, imem_rvalid_i};
            r_count    <= 3'd0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pq_rd    <= r_pq_wr;
        end else begin
            if (w_grant) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
                r_pq_wr    <= r_pq_wr + 1'b1;
            end
            r_inflight <= r_inflight + {2'b00, w_grant} - {2'b00, w_accept};
            r_discard  <= r_discard - {2'b00, w_drop};
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                r_pq_rd  <= r_pq_rd + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + {2'b00, w_push} - {2'b00, w_pop};
        end
    end

    // Storage arrays carry no reset; validity is tracked by the counters above.
    always_ff @(posedge clk_i) begin
        if (w_grant) begin
            r_pq[r_pq_wr] <= r_fetch_pc;
        end
        if (rst_i && w_push) begin
            r_fifo_pc[r_wr_ptr]    <= r_pq[r_pq_rd];
            r_fifo_instr[r_wr_ptr] <= imem_rdata_i;
        end
    end

    assign instr_valid_o = (r_count != 3'd0);
    assign instr_o       = instr_valid_o ? r_fifo_instr[r_rd_ptr] : 32'd0;
    assign pc_o          = instr_valid_o ? r_fifo_pc[r_rd_ptr] : 32'd0;
    assign pc_next_o     = pc_o + 32'd4;

endmodule
